// File: rtl/sram_access_ctrl.sv
// Two-port arbiter and access sequencer for the 2Kx16 SRAM: IDLE -> SETUP -> ACCESS x WAIT_CYC -> DONE.
// Optional macro SRAM_ARB_RR_EN selects round-robin arbitration; default is fixed priority (port 0 first).
module sram_access_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 1     // strobe width in cycles, 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] adx0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] adx1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [11:0]       sram_adx,
    output logic              sram_chpSel,
    output logic              sram_OutEn,
    output logic              sram_WrEn,
    inout  wire  [DATA_W-1:0] sram_data
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adx;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    state_t            state_q, state_d;
    acc_t              acc_q, acc_d;
    logic              tag_q, tag_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              busy_q, busy_d;
    logic              chpsel_q, chpsel_d;
    logic              outen_q, outen_d;
    logic              wren_q, wren_d;
    logic              arb;
    logic              win1;

`ifdef SRAM_ARB_RR_EN
    // ptr_q holds the most recently granted port; the other one wins a tie.
    logic ptr_q, ptr_d;

    assign win1 = req1 & (~req0 | ~ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (arb) ptr_d = win1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b1;
        else        ptr_q <= ptr_d;
    end
`else
    assign win1 = req1 & ~req0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        arb     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    arb     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!acc_q.we) rdata_d = sram_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Back-to-back: a pending request skips IDLE and keeps chip select low.
                if (req0 | req1) begin
                    arb     = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb) begin
            tag_d = win1;
            acc_d = win1 ? {we1, adx1, wdata1} : {we0, adx0, wdata0};
        end

        // Outputs are decoded from the next state so every pin comes straight off a flop.
        gnt0_d   = arb & ~win1;
        gnt1_d   = arb & win1;
        done0_d  = (state_d == DONE) & ~tag_d;
        done1_d  = (state_d == DONE) & tag_d;
        busy_d   = (state_d != IDLE);
        chpsel_d = (state_d == IDLE);
        outen_d  = ~((state_d == ACCESS) & ~acc_d.we);
        wren_d   = ~((state_d == ACCESS) & acc_d.we);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            tag_q    <= 1'b0;
            cnt_q    <= 4'd0;
            rdata_q  <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            chpsel_q <= 1'b1;
            outen_q  <= 1'b1;
            wren_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
            chpsel_q <= chpsel_d;
            outen_q  <= outen_d;
            wren_q   <= wren_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign busy        = busy_q;
    assign rdata       = rdata_q;
    assign sram_chpSel = chpsel_q;
    assign sram_OutEn  = outen_q;
    assign sram_WrEn   = wren_q;
    assign sram_adx    = 12'(acc_q.adx);

    // Bus enable is the write strobe flop itself, so reset releases the bus immediately.
    assign sram_data = wren_q ? {DATA_W{1'bz}} : acc_q.wdata;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: directed plan items plus randomized two-port traffic
// against a transaction-timing reference model and a behavioural SRAM.
module tb_sram_access_ctrl;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int W  = 3;
    localparam logic [DW-1:0] REL = 16'hFFFF;   // released bus reads back as the pull-up value

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] adx0 = '0, adx1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1, busy;
    logic          sram_chpSel, sram_OutEn, sram_WrEn;
    logic [DW-1:0] rdata;
    logic [11:0]   sram_adx;
    wire  [DW-1:0] sram_data;

    always #5 clk = ~clk;

    sram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .adx0(adx0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .we1(we1), .adx1(adx1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
        .rdata(rdata), .busy(busy), .sram_adx(sram_adx), .sram_chpSel(sram_chpSel),
        .sram_OutEn(sram_OutEn), .sram_WrEn(sram_WrEn), .sram_data(sram_data)
    );

    // Behavioural SRAM macro
    logic [DW-1:0] mem [0:2047];
    bit            mem_init = 1'b0;

    for (genvar gi = 0; gi < DW; gi++) begin : g_pu
        pullup (sram_data[gi]);
    end

    assign sram_data = (!sram_chpSel && !sram_OutEn && sram_WrEn) ? mem[sram_adx[10:0]] : {DW{1'bz}};

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
            mem_init <= 1'b1;
        end else if (!sram_chpSel && !sram_WrEn) begin
            mem[sram_adx[10:0]] <= sram_data;
        end
    end

    // Reference model: one access occupies edges [arb, arb+1+W]; next arbitration at arb+2+W.
    int            n_cmp = 0, n_err = 0;
    int            edge_n = 0, next_arb = 0, arb_edge = 0;
    bit            active = 1'b0, ptr = 1'b1, eg0, eg1;
    int            cur_port = 0;
    bit            cur_we = 1'b0;
    logic [AW-1:0] cur_adx = '0;
    logic [DW-1:0] cur_wd = '0;
    logic [DW-1:0] rdata_exp = '0;
    logic [DW-1:0] ref_mem [0:2047];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] rnd_adx();
        if ($urandom_range(0, 1) == 0) return 11'($urandom_range(0, 15));
        return 11'h7F0 + 11'($urandom_range(0, 15));
    endfunction

    task automatic model_reset();
        active = 1'b0; next_arb = 0; ptr = 1'b1; rdata_exp = '0;
    endtask

    task automatic step();
        int ph;
        bit p1, bsy, acc;
        @(posedge clk);
        edge_n++;
        if (active && edge_n == arb_edge + 1 + W) begin
            if (cur_we) ref_mem[cur_adx] = cur_wd;
            else        rdata_exp = ref_mem[cur_adx];
        end
        eg0 = 1'b0; eg1 = 1'b0;
        if (edge_n >= next_arb && (req0 || req1)) begin
`ifdef SRAM_ARB_RR_EN
            p1 = req1 && (!req0 || !ptr);
`else
            p1 = !req0;
`endif
            ptr = p1; active = 1'b1; arb_edge = edge_n; next_arb = edge_n + 2 + W;
            cur_port = int'(p1);
            cur_we  = p1 ? we1 : we0;
            cur_adx = p1 ? adx1 : adx0;
            cur_wd  = p1 ? wdata1 : wdata0;
            eg0 = !p1; eg1 = p1;
        end
        @(negedge clk);
        ph  = edge_n - arb_edge;
        bsy = active && ph <= W + 1;
        acc = active && ph >= 1 && ph <= W;
        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        chk("done0", done0, bsy && ph == W + 1 && cur_port == 0);
        chk("done1", done1, bsy && ph == W + 1 && cur_port == 1);
        chk("busy", busy, bsy);
        chk("chpSel", sram_chpSel, !bsy);
        chk("OutEn", sram_OutEn, !(acc && !cur_we));
        chk("WrEn", sram_WrEn, !(acc && cur_we));
        chk("strobe_excl", !sram_OutEn && !sram_WrEn, 1'b0);
        chk("adx_bit11", sram_adx[11], 1'b0);
        if (bsy) chk("sram_adx", sram_adx, {1'b0, cur_adx});
        if (acc && cur_we) chk("wr_bus", sram_data, cur_wd);
        else if (!acc)     chk("bus_released", sram_data, REL);
        chk("rdata", rdata, rdata_exp);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        if (p == 0) begin req0 = 1'b1; we0 = we; adx0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = we; adx1 = a; wdata1 = d; end
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = (p == 0) ? gnt0 : gnt1;
        end
        chk("gnt_seen", got, 1'b1);
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    initial begin
        int ng0, ng1, first_g, last_g, bgap;
        int oe_n, we_n, d1, d2, last_oe, first_we;

        for (int i = 0; i < 2048; i++) ref_mem[i] = 16'(i) ^ 16'h5A5A;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", {gnt0, gnt1}, 2'b00);
        chk("rst_done", {done0, done1}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {sram_chpSel, sram_OutEn, sram_WrEn}, 3'b111);
        chk("rst_adx", sram_adx, 12'h000);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_bus", sram_data, REL);
        rst_n = 1'b1;

        // Reset in the first ACCESS cycle of a write aborts it
        issue(0, 1'b1, 11'h005, 16'hBEEF);
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_WrEn", sram_WrEn, 1'b1);
        chk("abort_chpSel", sram_chpSel, 1'b1);
        chk("abort_bus", sram_data, REL);
        chk("abort_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", done0, 1'b0);
        end
        rst_n = 1'b1;
        model_reset();
        settle(2);

        // Write then read back through the other port
        issue(0, 1'b1, 11'h005, 16'hBEEF);
        settle(W + 3);
        issue(1, 1'b0, 11'h005, 16'h0000);
        settle(W + 3);
        chk("rd_beef", rdata, 16'hBEEF);

        // Address extremes
        issue(0, 1'b1, 11'h7FF, 16'h1234);
        issue(1, 1'b1, 11'h000, 16'hABCD);
        settle(W + 3);
        issue(0, 1'b0, 11'h7FF, 16'h0000);
        settle(W + 3);
        chk("rd_7ff", rdata, 16'h1234);
        issue(1, 1'b0, 11'h000, 16'h0000);
        settle(W + 3);
        chk("rd_000", rdata, 16'hABCD);

        // Contention: both ports keep requesting for four grants
        ng0 = 0; ng1 = 0; first_g = -1; last_g = 0; bgap = 0;
        req0 = 1'b1; we0 = 1'b1; adx0 = 11'h020; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b1; adx1 = 11'h030; wdata1 = 16'h2222;
        for (int i = 0; i < 60 && (ng0 + ng1) < 4; i++) begin
            step();
            if (gnt0 || gnt1) begin
                if (first_g < 0) first_g = edge_n;
                last_g = edge_n;
            end
            if (first_g >= 0 && !busy) bgap++;
            if (gnt0) begin ng0++; adx0 = rnd_adx(); wdata0 = 16'($urandom); end
            if (gnt1) begin ng1++; adx1 = rnd_adx(); wdata1 = 16'($urandom); end
        end
        req0 = 1'b0; req1 = 1'b0;
`ifdef SRAM_ARB_RR_EN
        chk("arb_gnt0_cnt", ng0, 2);
        chk("arb_gnt1_cnt", ng1, 2);
`else
        chk("arb_gnt0_cnt", ng0, 4);
        chk("arb_gnt1_cnt", ng1, 0);
`endif
        chk("b2b_span", last_g - first_g, 3 * (W + 2));
        chk("b2b_no_idle", bgap, 0);
        settle(W + 3);

        // Read then write back-to-back: strobe widths, turnaround, done spacing
        oe_n = 0; we_n = 0; d1 = -1; d2 = -1; last_oe = -1; first_we = -1;
        req0 = 1'b1; we0 = 1'b0; adx0 = 11'h7FF;
        req1 = 1'b1; we1 = 1'b1; adx1 = 11'h010; wdata1 = 16'h5555;
        for (int i = 0; i < 30; i++) begin
            step();
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            if (!sram_OutEn) begin oe_n++; last_oe = edge_n; end
            if (!sram_WrEn) begin we_n++; if (first_we < 0) first_we = edge_n; end
            if (done0 || done1) begin
                if (d1 < 0) d1 = edge_n; else d2 = edge_n;
            end
        end
        chk("rd_strobe_len", oe_n, W);
        chk("wr_strobe_len", we_n, W);
        chk("turnaround", (first_we - last_oe) > 1, 1'b1);
        chk("done_spacing", d2 - d1, W + 2);
        chk("rdata_hold", rdata, 16'h1234);

        // Randomized two-port traffic
        for (int c = 0; c < 600; c++) begin
            step();
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            if (!req0 && $urandom_range(0, 99) < 35) begin
                req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); adx0 = rnd_adx(); wdata0 = 16'($urandom);
            end else if (req0 && !gnt0 && $urandom_range(0, 99) < 3) begin
                req0 = 1'b0;
            end
            if (!req1 && $urandom_range(0, 99) < 35) begin
                req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); adx1 = rnd_adx(); wdata1 = 16'($urandom);
            end else if (req1 && !gnt1 && $urandom_range(0, 99) < 3) begin
                req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        settle(W + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
